// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS EX stage: ALU control codes, ID aluop classes,
// R-type function fields and the bundle of per-instruction control bits.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_BAD = 3'b111
  } alu_cntr_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Translates the ID aluop class and R-type funct into the 3-bit ALU control.
// Unknown R-type functions map to ALU_BAD so the ALU yields all ones.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] cntr
);

  always_comb begin
    cntr = ALU_BAD;
    case (aluop)
      ALUOP_ADD: cntr = ALU_ADD;
      ALUOP_SUB: cntr = ALU_SUB;
      ALUOP_OR:  cntr = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: cntr = ALU_ADD;
          FUNCT_SUB: cntr = ALU_SUB;
          FUNCT_AND: cntr = ALU_AND;
          FUNCT_OR:  cntr = ALU_OR;
          FUNCT_SLT: cntr = ALU_SLT;
          default:   cntr = ALU_BAD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-side forwarding muxes and load-use hazard
// detection; drives the ALU operands and control directly.
module ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [1:0]    id_aluop,
  input  logic [5:0]    id_funct,
  input  logic          id_alusrc,
  input  logic          id_uses_rt,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          id_branch,
  input  logic          stall,
  input  logic          flush,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_i0,
  output logic [DW-1:0] alu_i1,
  output logic [2:0]    alu_cntr,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rd,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_branch,
  output logic          load_use_hz
);

  logic [2:0]    id_cntr;
  ctrl_t         id_ctrl;

  logic          vld_p0;
  ctrl_t         ctrl_p0;
  logic [RW-1:0] rs_p0;
  logic [RW-1:0] rt_p0;
  logic [RW-1:0] rd_p0;
  logic [DW-1:0] rs_data_p0;
  logic [DW-1:0] rt_data_p0;
  logic [DW-1:0] imm_p0;
  logic [2:0]    cntr_p0;
  logic          alusrc_p0;

  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;

  alu_ctrl_decode u_alu_ctrl_decode (
    .aluop (id_aluop),
    .funct (id_funct),
    .cntr  (id_cntr)
  );

  assign id_ctrl = '{regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
                     memtoreg: id_memtoreg, branch: id_branch};

  // Raw hazard against the load now in EX; upstream stall/flush do not mask it.
  assign load_use_hz = vld_p0 & ctrl_p0.memread & (rd_p0 != '0) & id_valid &
                       ((rd_p0 == id_rs) | (id_uses_rt & (rd_p0 == id_rt)));

  // ---- ID -> EX boundary: flush > stall > hazard bubble > load ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      ctrl_p0    <= '0;
      rs_p0      <= '0;
      rt_p0      <= '0;
      rd_p0      <= '0;
      rs_data_p0 <= '0;
      rt_data_p0 <= '0;
      imm_p0     <= '0;
      cntr_p0    <= '0;
      alusrc_p0  <= 1'b0;
    end else if (flush || (!stall && load_use_hz)) begin
      vld_p0     <= 1'b0;
      ctrl_p0    <= '0;
      rs_p0      <= '0;
      rt_p0      <= '0;
      rd_p0      <= '0;
      rs_data_p0 <= '0;
      rt_data_p0 <= '0;
      imm_p0     <= '0;
      cntr_p0    <= '0;
      alusrc_p0  <= 1'b0;
    end else if (!stall) begin
      vld_p0     <= id_valid;
      ctrl_p0    <= id_ctrl;
      rs_p0      <= id_rs;
      rt_p0      <= id_rt;
      rd_p0      <= id_rd;
      rs_data_p0 <= id_rs_data;
      rt_data_p0 <= id_rt_data;
      imm_p0     <= id_imm;
      cntr_p0    <= id_cntr;
      alusrc_p0  <= id_alusrc;
    end
  end

  // Youngest producer (EX/MEM) wins; $0 is hard-wired and never forwarded.
  always_comb begin
    rs_fwd = rs_data_p0;
    if (exmem_regwrite && (exmem_rd == rs_p0) && (rs_p0 != '0))
      rs_fwd = exmem_result;
    else if (memwb_regwrite && (memwb_rd == rs_p0) && (rs_p0 != '0))
      rs_fwd = memwb_result;

    rt_fwd = rt_data_p0;
    if (exmem_regwrite && (exmem_rd == rt_p0) && (rt_p0 != '0))
      rt_fwd = exmem_result;
    else if (memwb_regwrite && (memwb_rd == rt_p0) && (rt_p0 != '0))
      rt_fwd = memwb_result;
  end

  assign alu_i0        = rs_fwd;
  assign alu_i1        = alusrc_p0 ? imm_p0 : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_cntr      = cntr_p0;
  assign ex_valid      = vld_p0;
  assign ex_rd         = rd_p0;

  assign ex_regwrite = vld_p0 & ctrl_p0.regwrite;
  assign ex_memread  = vld_p0 & ctrl_p0.memread;
  assign ex_memwrite = vld_p0 & ctrl_p0.memwrite;
  assign ex_memtoreg = vld_p0 & ctrl_p0.memtoreg;
  assign ex_branch   = vld_p0 & ctrl_p0.branch;

endmodule
